// File: rtl/seq_gen_arbiter_pkg.sv
// Shared types and widths for the sequence-generator arbiter.
package seq_gen_arbiter_pkg;
  localparam int unsigned N_REQ = 2;
  localparam int unsigned GEN_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/seq_gen_arbiter_rr_arb2.sv
// Combinational two-way round-robin select: the requester other than i_last wins a tie.
module rr_arb2
  import seq_gen_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_last,
  output logic             o_winner,
  output logic             o_any
);
  assign o_any    = |i_req;
  assign o_winner = (&i_req) ? ~i_last : i_req[1];
endmodule

// File: rtl/seq_gen_arbiter.sv
// Shares one 3-bit sequence generator between two burst requesters:
// round-robin grant, generator clear, N step enables, forwarded data and done pulse.
module seq_gen_arbiter
  import seq_gen_arbiter_pkg::*;
#(
  parameter int unsigned STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  input  logic [STEP_W-1:0] len0,
  input  logic [STEP_W-1:0] len1,
  output logic [N_REQ-1:0]  gnt,
  output logic [N_REQ-1:0]  done,
  output logic              gen_clr,
  output logic              gen_en,
  input  logic [GEN_W-1:0]  gen_q,
  output logic [GEN_W-1:0]  data_out,
  output logic              data_vld
);
  state_t            r_state;
  state_t            w_state_nxt;
  logic [STEP_W-1:0] r_cnt;
  logic              r_last;
  logic              r_win;
  logic [N_REQ-1:0]  r_gnt;
  logic [N_REQ-1:0]  r_done;
  logic              r_gen_clr;
  logic              r_data_vld;

  logic              w_arb_win;
  logic              w_arb_any;
  logic              w_abort;
  logic              w_win_nxt;
  logic [N_REQ-1:0]  w_oh_nxt;
  logic [N_REQ-1:0]  w_gnt_nxt;
  logic [N_REQ-1:0]  w_done_nxt;
  logic              w_clr_nxt;
  logic              w_gen_en;

  rr_arb2 u_arb (
    .i_req    (req),
    .i_last   (r_last),
    .o_winner (w_arb_win),
    .o_any    (w_arb_any)
  );

  // Winner dropping its request mid-burst abandons the burst.
  assign w_abort = ((r_state == CLEAR) || (r_state == RUN)) && !req[r_win];

  // State, counter, pointer and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_last     <= 1'b1;
      r_win      <= 1'b0;
      r_gnt      <= '0;
      r_done     <= '0;
      r_gen_clr  <= 1'b0;
      r_data_vld <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_done     <= w_done_nxt;
      r_gen_clr  <= w_clr_nxt;
      r_data_vld <= w_gen_en;
      if ((r_state == IDLE) && w_arb_any) begin
        r_win <= w_arb_win;
        r_cnt <= w_arb_win ? len1 : len0;
      end else if ((r_state == RUN) && !w_abort) begin
        r_cnt <= r_cnt - STEP_W'(1);
      end
      if ((r_state == DONE) || w_abort) begin
        r_last <= r_win;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_arb_any) w_state_nxt = CLEAR;
      CLEAR: begin
        if (w_abort)                 w_state_nxt = IDLE;
        else if (r_cnt == '0)        w_state_nxt = DONE;
        else                         w_state_nxt = RUN;
      end
      RUN: begin
        if (w_abort)                 w_state_nxt = IDLE;
        else if (r_cnt == STEP_W'(1)) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output logic; gen_en follows req directly so an abort stops stepping at once
  always_comb begin
    w_win_nxt  = (r_state == IDLE) ? w_arb_win : r_win;
    w_oh_nxt   = w_win_nxt ? 2'b10 : 2'b01;
    w_gnt_nxt  = '0;
    w_done_nxt = '0;
    w_clr_nxt  = 1'b0;
    w_gen_en   = 1'b0;
    if (w_state_nxt != IDLE) w_gnt_nxt  = w_oh_nxt;
    if (w_state_nxt == DONE) w_done_nxt = w_oh_nxt;
    if (w_state_nxt == CLEAR) w_clr_nxt = 1'b1;
    if ((r_state == RUN) && req[r_win]) w_gen_en = 1'b1;
  end

  assign gnt      = r_gnt;
  assign done     = r_done;
  assign gen_clr  = r_gen_clr;
  assign gen_en   = w_gen_en;
  assign data_vld = r_data_vld;
  assign data_out = gen_q;
endmodule

// File: tb/tb_seq_gen_arbiter.sv
// Directed self-checking bench for seq_gen_arbiter with a behavioural 3-bit generator.
module tb_seq_gen_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] req = 2'b00;
  logic [3:0] len0 = 4'd0;
  logic [3:0] len1 = 4'd0;
  logic [1:0] gnt, done;
  logic       gen_clr, gen_en, data_vld;
  logic [2:0] gen_q, data_out;

  int checks = 0;
  int errors = 0;

  logic [2:0] seq [8] = '{3'b010, 3'b111, 3'b100, 3'b101, 3'b001, 3'b011, 3'b110, 3'b000};

  seq_gen_arbiter #(.STEP_W(4)) dut (
    .clk(clk), .rst(rst), .req(req), .len0(len0), .len1(len1),
    .gnt(gnt), .done(done), .gen_clr(gen_clr), .gen_en(gen_en),
    .gen_q(gen_q), .data_out(data_out), .data_vld(data_vld)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] gen_next(input logic [2:0] q);
    case (q)
      3'b000: gen_next = 3'b010;
      3'b010: gen_next = 3'b111;
      3'b111: gen_next = 3'b100;
      3'b100: gen_next = 3'b101;
      3'b101: gen_next = 3'b001;
      3'b001: gen_next = 3'b011;
      3'b011: gen_next = 3'b110;
      default: gen_next = 3'b000;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         gen_q <= 3'b000;
    else if (gen_clr) gen_q <= 3'b000;
    else if (gen_en)  gen_q <= gen_next(gen_q);
  end

  // Observed row: {gnt, done, gen_clr, gen_en, data_vld}
  function automatic logic [6:0] obs();
    return {gnt, done, gen_clr, gen_en, data_vld};
  endfunction

  // Expected row for cycle c of an uninterrupted burst of length l won by requester id
  function automatic logic [6:0] exp_row(input int c, input int l, input int id);
    logic [1:0] oh;
    oh = (id == 1) ? 2'b10 : 2'b01;
    return {(c <= l + 2) ? oh : 2'b00, (c == l + 2) ? oh : 2'b00,
            1'(c == 1), 1'(c >= 2 && c <= l + 1), 1'(c >= 3 && c <= l + 2)};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req = 2'b00;
    repeat (n) next_cycle();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      checks++;
      if (obs() !== 7'b0) begin
        errors++;
        $display("FAIL reset_outputs got %b want %b", obs(), 7'b0);
      end
    end
  endtask

  task automatic test_contention();
    logic [6:0] e;
    int         cc;
    req = 2'b11; len0 = 4'd2; len1 = 4'd3;
    rst = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      next_cycle();
      if (c <= 5) begin e = exp_row(c, 2, 0); cc = c; end
      else if (c <= 11) begin e = exp_row(c - 5, 3, 1); cc = c - 5; end
      else begin e = 7'b01_00_100; cc = 0; end
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL contention_row c=%0d got %b want %b", c, obs(), e);
      end
      if (e[0]) begin
        checks++;
        if (data_out !== seq[cc - 3]) begin
          errors++;
          $display("FAIL contention_data c=%0d got %b want %b", c, data_out, seq[cc - 3]);
        end
      end
      if (c == 10) req = 2'b01;
    end
    idle(3);
  endtask

  task automatic test_single();
    logic [6:0] e;
    req = 2'b01; len0 = 4'd4;
    for (int c = 1; c <= 8; c++) begin
      next_cycle();
      e = exp_row(c, 4, 0);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL single_row c=%0d got %b want %b", c, obs(), e);
      end
      if (e[0]) begin
        checks++;
        if (data_out !== seq[c - 3]) begin
          errors++;
          $display("FAIL single_data c=%0d got %b want %b", c, data_out, seq[c - 3]);
        end
      end
      if (c == 6) req = 2'b00;
    end
    idle(2);
  endtask

  task automatic test_zero_len();
    logic [6:0] e;
    req = 2'b10; len1 = 4'd0;
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      e = exp_row(c, 0, 1);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL zero_len_row c=%0d got %b want %b", c, obs(), e);
      end
      if (c == 2) req = 2'b00;
    end
    idle(2);
  endtask

  task automatic test_abort();
    logic [6:0] tbl [6] = '{7'b01_00_100, 7'b01_00_010, 7'b01_00_011,
                            7'b01_00_001, 7'b00_00_000, 7'b10_00_100};
    logic [2:0] dat [6] = '{3'b000, 3'b000, 3'b010, 3'b111, 3'b000, 3'b000};
    req = 2'b01; len0 = 4'd7; len1 = 4'd5;
    for (int c = 1; c <= 6; c++) begin
      next_cycle();
      if (c == 4) begin
        req = 2'b10;
        #1;
      end
      checks++;
      if (obs() !== tbl[c - 1]) begin
        errors++;
        $display("FAIL abort_row c=%0d got %b want %b", c, obs(), tbl[c - 1]);
      end
      if (tbl[c - 1][0]) begin
        checks++;
        if (data_out !== dat[c - 1]) begin
          errors++;
          $display("FAIL abort_data c=%0d got %b want %b", c, data_out, dat[c - 1]);
        end
      end
      if (c == 2) req = 2'b11;
    end
    idle(3);
  endtask

  task automatic test_max_len();
    logic [6:0] e;
    int         vld_cnt = 0;
    req = 2'b01; len0 = 4'd15;
    for (int c = 1; c <= 18; c++) begin
      next_cycle();
      e = exp_row(c, 15, 0);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL max_len_row c=%0d got %b want %b", c, obs(), e);
      end
      if (data_vld) vld_cnt++;
      if (e[0]) begin
        checks++;
        if (data_out !== seq[(c - 3) % 8]) begin
          errors++;
          $display("FAIL max_len_data c=%0d got %b want %b", c, data_out, seq[(c - 3) % 8]);
        end
      end
      if (c == 17) req = 2'b00;
    end
    checks++;
    if (vld_cnt != 15) begin
      errors++;
      $display("FAIL max_len_vld_count got %0d want 15", vld_cnt);
    end
    idle(2);
  endtask

  task automatic test_reset_mid();
    logic [6:0] e;
    req = 2'b10; len1 = 4'd7;
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      e = exp_row(c, 7, 1);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL reset_mid_pre c=%0d got %b want %b", c, obs(), e);
      end
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (obs() !== 7'b0) begin
      errors++;
      $display("FAIL reset_mid_async got %b want %b", obs(), 7'b0);
    end
    @(negedge clk);
    req = 2'b11;
    rst = 1'b1;
    next_cycle();
    checks++;
    if (obs() !== 7'b01_00_100) begin
      errors++;
      $display("FAIL reset_mid_priority got %b want %b", obs(), 7'b01_00_100);
    end
    idle(3);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_contention();
    test_single();
    test_zero_len();
    test_abort();
    test_max_len();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_gen_arbiter.md
# seq_gen_arbiter

Controller that shares one 3-bit sequence generator between two requesters. Each requester asks for a burst of N generator steps. The block arbitrates round-robin and issues a synchronous clear to the generator. It then drives the generator's step enable N times, forwards each new generator value with a valid flag, and signals completion to the winner. It sits between the generator and its consumers. The generator is the team's registered 3-bit sequencer, with sequence 000→010→111→100→101→001→011→110→000, extended with synchronous clear and step enable.

## Interface
Parameters:
- STEP_W, 4, width of burst-length inputs; max burst 2^STEP_W−1 steps

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  2  per-requester request, level; held high until matching done
- len0  in  STEP_W  burst length for requester 0, sampled on grant
- len1  in  STEP_W  burst length for requester 1, sampled on grant
- gnt  out  2  one-hot grant, registered
- done  out  2  one-cycle completion pulse per requester
- gen_clr  out  1  synchronous clear to generator (next state 000)
- gen_en  out  1  generator step enable
- gen_q  in  3  generator state output
- data_out  out  3  equals gen_q (combinational pass-through)
- data_vld  out  1  data_out holds a new step value for the granted requester

## Operation
- States: IDLE, CLEAR, RUN, DONE. Encoding is 2-bit binary.
- IDLE:
  - If req≠0, select the winner, set gnt, and go to CLEAR.
  - Otherwise stay; all outputs are 0.
- Arbitration:
  - Round-robin pointer `last` (1 bit) holds the last-served index.
  - With both requests pending, the requester ≠ last wins. A single request wins unconditionally.
  - `last` updates on leaving DONE and on abort.
- CLEAR:
  - gen_clr=1 for exactly one cycle.
  - Load step counter cnt ← len of winner.
  - If len=0, go to DONE (zero steps, no data_vld). Otherwise go to RUN.
- RUN:
  - gen_en=1 every cycle; cnt decrements.
  - When cnt reaches 1 in this cycle, next state is DONE.
- data_vld = gen_en registered one cycle. data_out is valid only while data_vld=1.
- DONE:
  - done[winner]=1 for one cycle; gnt stays high this cycle.
  - Next state is IDLE with gnt cleared.
- Abort: if req[winner] drops in CLEAR or RUN:
  - Next state is IDLE; gen_en deasserts immediately; gnt clears next cycle.
  - No done pulse; `last` ← winner.
  - One trailing data_vld may follow a final gen_en; consumers ignore it without gnt.
- A new request, or a request change for the loser, during a burst is ignored until IDLE.
- gen_clr and gen_en are never high in the same cycle.

## Timing
- Reset (rst=0, async): state IDLE, gnt=0, done=0, gen_clr=0, gen_en=0, data_vld=0, cnt=0, last=1 (requester 0 has priority first).
- Deassertion of rst is synchronized externally. The first active edge may see req.
- Burst of length L≥1, with req rising before edge 0:
  - cycle 1: gnt, gen_clr
  - cycles 2..L+1: gen_en
  - cycles 3..L+2: data_vld
  - cycle L+2: done
  - cycle L+3: gnt=0, IDLE
- Earliest next grant is cycle L+4, so there are 2 idle-overhead cycles between back-to-back bursts.
- L=0: gnt in cycles 1..2, gen_clr in cycle 1, done in cycle 2.

## Structure
- Package seq_gen_arbiter_pkg holds:
  - state enum: IDLE, CLEAR, RUN, DONE
  - constant N_REQ=2
  - constant GEN_W=3
- Sub-module rr_arb2 is combinational two-way round-robin selection (req, last → winner, any). The main FSM, counter and pointer register stay in seq_gen_arbiter.

## Test plan
- Reset mid-burst: assert rst=0 in RUN. All outputs go 0 asynchronously, and after release the block is in IDLE with requester 0 priority.
- Single burst: req=01, len0=4. gen_clr in cycle 1; data_out 010,111,100,101 on data_vld cycles 3–6; done=01 in cycle 6.
- Contention: req=11 from reset, len0=2, len1=3.
  - Requester 0 gets 010,111 and done.
  - Requester 1 is then granted at cycle 6, receives 010,111,100 and done=10.
  - Requester 0 held high then wins next.
- Zero length: req=10, len1=0. gnt=10 for two cycles, done=10 in cycle 2, gen_en never high.
- Abort: req=01, len0=7, drop req0 in the 3rd RUN cycle. gen_en stops, no done, gnt=0 next cycle, and a pending req1 is granted.
- Max length: len0=15 yields 15 data_vld with values wrapping past 110→000; done=01 in cycle 17.
